// File: rtl/pool_ctrl_pkg.sv
// Shared types and constants for the 2x2 average-pooling controller.
package pool_ctrl_pkg;

  // Q5.11 signed fixed-point pixel format
  localparam int Q_INT_W  = 5;
  localparam int Q_FRAC_W = 11;

  // Default geometry
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = Q_INT_W + Q_FRAC_W;
  localparam int DEF_MAX_N  = 32;

  // Width of the map_size port
  localparam int MAP_W = 6;

  // A sum of four words needs two guard bits; >>> 2 then restores Q5.11 scaling
  localparam int SUM_GUARD_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    RD0,
    RD1,
    RD2,
    RD3,
    LAST,
    WR,
    FIN
  } state_e;

  // Legal map sides are even and in 2..max_n
  function automatic logic size_is_legal(input logic [MAP_W-1:0] n, input int max_n);
    return (n[0] == 1'b0) && (int'(n) >= 2) && (int'(n) <= max_n);
  endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// Window counters and address generation for the pooling controller.
// Keeps the address of source row 2i incrementally so no multiplier is needed.
module pool_addr_gen
  import pool_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              advance,
  input  logic [MAP_W-1:0]  map_size,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [1:0]        rd_phase,
  input  logic              rd_en,
  input  logic              wr_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              last_win
);

  logic [MAP_W-1:0]  n_q, n_d;
  logic [MAP_W-1:0]  row_idx_q, row_idx_d;
  logic [MAP_W-1:0]  col_idx_q, col_idx_d;
  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;

  logic [MAP_W-1:0]  last_idx;
  logic [ADDR_W-1:0] n_ext;
  logic [ADDR_W-1:0] win_base;

  assign last_idx = (n_q >> 1) - MAP_W'(1);
  assign last_win = (row_idx_q == last_idx) && (col_idx_q == last_idx);
  assign n_ext    = ADDR_W'(n_q);
  assign win_base = row_base_q + ADDR_W'({col_idx_q, 1'b0});

  // Counter and pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q        <= '0;
      row_idx_q  <= '0;
      col_idx_q  <= '0;
      row_base_q <= '0;
      wr_ptr_q   <= '0;
    end else begin
      n_q        <= n_d;
      row_idx_q  <= row_idx_d;
      col_idx_q  <= col_idx_d;
      row_base_q <= row_base_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Load job geometry on accept; step j fastest, then i, after each write
  always_comb begin
    n_d        = n_q;
    row_idx_d  = row_idx_q;
    col_idx_d  = col_idx_q;
    row_base_d = row_base_q;
    wr_ptr_d   = wr_ptr_q;
    if (init) begin
      n_d        = map_size;
      row_idx_d  = '0;
      col_idx_d  = '0;
      row_base_d = src_base;
      wr_ptr_d   = dst_base;
    end else if (advance) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      if (col_idx_q == last_idx) begin
        col_idx_d  = '0;
        row_idx_d  = row_idx_q + MAP_W'(1);
        row_base_d = row_base_q + ADDR_W'({n_q, 1'b0});
      end else begin
        col_idx_d = col_idx_q + MAP_W'(1);
      end
    end
  end

  // Read address of the current window pixel; both addresses idle at zero
  always_comb begin
    rd_addr = '0;
    wr_addr = '0;
    if (rd_en) begin
      case (rd_phase)
        2'd0: rd_addr = win_base;
        2'd1: rd_addr = win_base + ADDR_W'(1);
        2'd2: rd_addr = win_base + n_ext;
        2'd3: rd_addr = win_base + n_ext + ADDR_W'(1);
      endcase
    end
    if (wr_en) begin
      wr_addr = wr_ptr_q;
    end
  end

endmodule

// File: rtl/pool_controller.sv
// 2x2 stride-2 average pooling controller: reads each window pixel by pixel,
// accumulates in an 18-bit signed sum and writes the floor-rounded average.
module pool_controller
  import pool_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int MAX_N  = DEF_MAX_N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MAP_W-1:0]  map_size,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int SUM_W = DATA_W + SUM_GUARD_W;

  state_e                    state_q, state_d;
  logic signed [SUM_W-1:0]   acc_q, acc_d;
  logic                      err_q, err_d;

  logic                      addr_init;
  logic                      addr_adv;
  logic                      last_win;
  logic [1:0]                rd_phase;
  logic signed [SUM_W-1:0]   rd_ext;

  assign rd_ext = {{SUM_GUARD_W{rd_data[DATA_W-1]}}, rd_data};
  assign busy   = (state_q != IDLE);

  // State, accumulator and pending-error registers
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end

  // Next state, accumulator update and Moore outputs
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d   = state_q;
    acc_d     = acc_q;
    err_d     = err_q;
    addr_init = 1'b0;
    addr_adv  = 1'b0;
    rd_phase  = 2'd0;
    rd_en     = 1'b0;
    wr_en     = 1'b0;
    wr_data   = '0;
    done      = 1'b0;
    err       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (size_is_legal(map_size, MAX_N)) begin
            state_d   = RD0;
            err_d     = 1'b0;
            addr_init = 1'b1;
          end else begin
            state_d = FIN;
            err_d   = 1'b1;
          end
        end
      end
      RD0: begin
        rd_en    = 1'b1;
        rd_phase = 2'd0;
        acc_d    = '0;
        state_d  = RD1;
      end
      RD1: begin
        rd_en    = 1'b1;
        rd_phase = 2'd1;
        acc_d    = acc_q + rd_ext;
        state_d  = RD2;
      end
      RD2: begin
        rd_en    = 1'b1;
        rd_phase = 2'd2;
        acc_d    = acc_q + rd_ext;
        state_d  = RD3;
      end
      RD3: begin
        rd_en    = 1'b1;
        rd_phase = 2'd3;
        acc_d    = acc_q + rd_ext;
        state_d  = LAST;
      end
      LAST: begin
        acc_d   = acc_q + rd_ext;
        state_d = WR;
      end
      WR: begin
        wr_en    = 1'b1;
        // Bits [DATA_W+1:2] are the arithmetic >>> 2 truncated to DATA_W (floor)
        wr_data  = acc_q[DATA_W+1:2];
        addr_adv = 1'b1;
        state_d  = last_win ? FIN : RD0;
      end
      FIN: begin
        done    = 1'b1;
        err     = err_q;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  pool_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .init     (addr_init),
    .advance  (addr_adv),
    .map_size (map_size),
    .src_base (src_base),
    .dst_base (dst_base),
    .rd_phase (rd_phase),
    .rd_en    (rd_en),
    .wr_en    (wr_en),
    .rd_addr  (rd_addr),
    .wr_addr  (wr_addr),
    .last_win (last_win)
  );

endmodule
